// File: rtl/pio_gen_pkg.sv
// Shared constants for the parametrised Avalon-MM PIO peripheral.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
package pio_gen_pkg;

  // Word addresses of the register map
  localparam logic [2:0] ADDR_DATA = 3'd0;
  localparam logic [2:0] ADDR_OUT  = 3'd1;
  localparam logic [2:0] ADDR_MASK = 3'd2;
  localparam logic [2:0] ADDR_EDGE = 3'd3;
  localparam logic [2:0] ADDR_SET  = 3'd4;
  localparam logic [2:0] ADDR_CLR  = 3'd5;
  localparam logic [2:0] ADDR_CFG  = 3'd6;
  localparam logic [2:0] ADDR_RSVD = 3'd7;

  // Edge-capture event selection
  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_BOTH = 2;

  // Width of a counter that must reach n; at least one bit so a bypassed
  // debouncer still has a legal declaration.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/pio_debounce.sv
// One input bit: 2-FF synchroniser followed by a stability-counter debouncer.
// Latency: 2 cycles to the synchronised value, plus DEBOUNCE_CYCLES when debouncing.
// Backpressure: none; free-running on every clock.
module pio_debounce
  import pio_gen_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic level
);

  logic [1:0] sync_q;

  // Two-stage synchroniser for the asynchronous pin
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], pin};
    end
  end

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      assign level = sync_q[1];
    end else begin : g_count
      localparam int CW = cnt_width(DEBOUNCE_CYCLES);
      localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

      logic [CW-1:0] cnt;
      logic          level_q;

      // Count consecutive cycles of disagreement; accept the new level on the
      // last one. Any agreement restarts the count, so glitches are dropped
      // and the counter never runs past LAST.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt     <= '0;
          level_q <= 1'b0;
        end else if (sync_q[1] == level_q) begin
          cnt <= '0;
        end else if (cnt == LAST) begin
          cnt     <= '0;
          level_q <= sync_q[1];
        end else begin
          cnt <= cnt + CW'(1);
        end
      end

      assign level = level_q;
    end
  endgenerate

endmodule

// File: rtl/pio_gen_avalon.sv
// General-purpose I/O with Avalon-MM slave: output register, debounced inputs, edge-capture IRQ.
// Latency: reads return 1 cycle after avs_read; writes take effect at the sampling edge.
// Backpressure: none; the slave never stalls (no waitrequest), every access completes.
module pio_gen_avalon
  import pio_gen_pkg::*;
#(
  parameter int             IN_W            = 8,
  parameter int             OUT_W           = 8,
  parameter int             DEBOUNCE_CYCLES = 50000,
  parameter int             EDGE_MODE       = 0,
  parameter logic [OUT_W-1:0] OUT_RESET     = '0
) (
  input  logic             clk_clk,
  input  logic             reset_reset_n,
  input  logic [2:0]       avs_address,
  input  logic             avs_read,
  input  logic             avs_write,
  input  logic [31:0]      avs_writedata,
  output logic [31:0]      avs_readdata,
  output logic             irq,
  input  logic [IN_W-1:0]  pio_in_export,
  output logic [OUT_W-1:0] pio_out_export
);

  logic [IN_W-1:0]  data;       // debounced inputs
  logic [IN_W-1:0]  prev;       // debounced inputs, one cycle old
  logic [IN_W-1:0]  event_hit;  // edge events this cycle
  logic [IN_W-1:0]  edge_clr;   // W1C bits from a write to EDGE
  logic [IN_W-1:0]  edge_q;
  logic [IN_W-1:0]  mask_q;
  logic [OUT_W-1:0] out_q;
  logic [31:0]      rd_mux;
  logic             unused_wdata;

  // Bits above IN_W/OUT_W are deliberately dropped on write
  assign unused_wdata = ^avs_writedata;

  for (genvar i = 0; i < IN_W; i++) begin : g_in
    pio_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk  (clk_clk),
      .rst_n(reset_reset_n),
      .pin  (pio_in_export[i]),
      .level(data[i])
    );
  end

  // Per-bit event detection on the debounced value
  always_comb begin
    event_hit = '0;
    case (EDGE_MODE)
      EDGE_RISE: event_hit = data & ~prev;
      EDGE_FALL: event_hit = ~data & prev;
      EDGE_BOTH: event_hit = data ^ prev;
      default:   event_hit = data & ~prev;
    endcase
  end

  // Write-one-to-clear mask for EDGE, only on a write to that address
  always_comb begin
    edge_clr = '0;
    if (avs_write && (avs_address == ADDR_EDGE)) begin
      edge_clr = avs_writedata[IN_W-1:0];
    end
  end

  // Previous debounced value and edge capture; a new event beats a same-cycle clear
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      prev   <= '0;
      edge_q <= '0;
    end else begin
      prev   <= data;
      edge_q <= (edge_q & ~edge_clr) | event_hit;
    end
  end

  // Writable control registers: OUT (direct, set, clear) and IRQ_MASK
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      out_q  <= OUT_RESET;
      mask_q <= '0;
    end else if (avs_write) begin
      case (avs_address)
        ADDR_OUT:  out_q  <= avs_writedata[OUT_W-1:0];
        ADDR_SET:  out_q  <= out_q | avs_writedata[OUT_W-1:0];
        ADDR_CLR:  out_q  <= out_q & ~avs_writedata[OUT_W-1:0];
        ADDR_MASK: mask_q <= avs_writedata[IN_W-1:0];
        default:   ;
      endcase
    end
  end

  // Read mux; write-only and reserved addresses return zero
  always_comb begin
    rd_mux = '0;
    case (avs_address)
      ADDR_DATA: rd_mux = 32'(data);
      ADDR_OUT:  rd_mux = 32'(out_q);
      ADDR_MASK: rd_mux = 32'(mask_q);
      ADDR_EDGE: rd_mux = 32'(edge_q);
      ADDR_CFG:  rd_mux = {16'(IN_W), 16'(OUT_W)};
      default:   rd_mux = '0;
    endcase
  end

  // Registered read data; holds between reads and sees pre-write register state
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      avs_readdata <= '0;
    end else if (avs_read) begin
      avs_readdata <= rd_mux;
    end
  end

  assign irq            = |(edge_q & mask_q);
  assign pio_out_export = out_q;

endmodule

// File: tb/tb_pio_gen_avalon.sv
// Self-checking bench for pio_gen_avalon with a read-data scoreboard.
// Latency: expects read data one cycle after each read strobe.
// Backpressure: none exercised; the slave never stalls.
module tb_pio_gen_avalon;
  import pio_gen_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;
  logic        irq;
  logic [7:0]  pio_in;
  logic [7:0]  pio_out;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];
  logic        rd_seen = 1'b0;

  pio_gen_avalon #(
    .IN_W           (8),
    .OUT_W          (8),
    .DEBOUNCE_CYCLES(16),
    .EDGE_MODE      (0),
    .OUT_RESET      (8'hA5)
  ) dut (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .avs_address   (avs_address),
    .avs_read      (avs_read),
    .avs_write     (avs_write),
    .avs_writedata (avs_writedata),
    .avs_readdata  (avs_readdata),
    .irq           (irq),
    .pio_in_export (pio_in),
    .pio_out_export(pio_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Remember which edges sampled a read so the monitor knows when data is due
  always @(posedge clk) rd_seen <= avs_read;

  // Scoreboard: pop the expected value when registered read data appears
  always @(negedge clk) begin
    if (rd_seen) begin
      if (exp_q.size() == 0) begin
        chk("sb_underflow", 32'd1, 32'd0);
      end else begin
        logic [31:0] e;
        string       t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        chk(t, avs_readdata, e);
      end
    end
  end

  // All tasks start just after a negedge and return at the next negedge
  task automatic bus_cycle(input logic rd, input logic wr, input logic [2:0] addr,
                           input logic [31:0] wdata, input logic [31:0] exp, input string tag);
    avs_read      = rd;
    avs_write     = wr;
    avs_address   = addr;
    avs_writedata = wdata;
    if (rd) begin
      exp_q.push_back(exp);
      tag_q.push_back(tag);
    end
    @(negedge clk);
    avs_read  = 1'b0;
    avs_write = 1'b0;
  endtask

  task automatic wr(input logic [2:0] addr, input logic [31:0] wdata);
    bus_cycle(1'b0, 1'b1, addr, wdata, 32'h0, "");
  endtask

  task automatic rd(input logic [2:0] addr, input logic [31:0] exp, input string tag);
    bus_cycle(1'b1, 1'b0, addr, 32'h0, exp, tag);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst_n         = 1'b0;
    avs_address   = 3'd0;
    avs_read      = 1'b0;
    avs_write     = 1'b0;
    avs_writedata = 32'h0;
    pio_in        = 8'h00;
    idle(3);

    // Reset state
    chk("rst_out", 32'(pio_out), 32'h0000_00A5);
    chk("rst_irq", 32'(irq), 32'h0);
    chk("rst_rdata", avs_readdata, 32'h0);
    rst_n = 1'b1;
    idle(2);

    rd(ADDR_CFG,  32'h0008_0008, "cfg");
    rd(ADDR_OUT,  32'h0000_00A5, "out_rst");
    rd(ADDR_MASK, 32'h0, "mask_rst");
    rd(ADDR_EDGE, 32'h0, "edge_rst");
    rd(ADDR_DATA, 32'h0, "data_rst");

    // Output register operations
    wr(ADDR_OUT, 32'h0000_000F);
    chk("out_wr", 32'(pio_out), 32'h0F);
    wr(ADDR_SET, 32'h0000_00F0);
    chk("out_set", 32'(pio_out), 32'hFF);
    wr(ADDR_CLR, 32'h0000_0081);
    chk("out_clr", 32'(pio_out), 32'h7E);
    rd(ADDR_SET,  32'h0, "rd_set_zero");
    rd(ADDR_CLR,  32'h0, "rd_clr_zero");
    wr(ADDR_RSVD, 32'hFFFF_FFFF);
    rd(ADDR_RSVD, 32'h0, "rd_rsvd_zero");
    rd(ADDR_OUT,  32'h0000_007E, "rd_out");
    wr(ADDR_OUT,  32'hFFFF_FF3C);
    rd(ADDR_OUT,  32'h0000_003C, "out_upper_ignored");
    idle(2);
    chk("rdata_hold", avs_readdata, 32'h0000_003C);
    bus_cycle(1'b1, 1'b1, ADDR_OUT, 32'h0000_0055, 32'h0000_003C, "rw_same_cycle");
    rd(ADDR_OUT, 32'h0000_0055, "out_after_rw");

    wr(ADDR_MASK, 32'hFFFF_FF01);
    rd(ADDR_MASK, 32'h0000_0001, "mask_rd");

    // Glitch shorter than the debounce period never reaches DATA
    pio_in = 8'h01;
    idle(10);
    pio_in = 8'h00;
    for (int j = 0; j < 24; j++) rd(ADDR_DATA, 32'h0, "glitch_data");
    rd(ADDR_EDGE, 32'h0, "glitch_edge");

    // Held input: DATA after 18 edges, EDGE/irq one edge later
    pio_in = 8'h01;
    for (int j = 0; j < 20; j++) begin
      chk($sformatf("irq_lat_%0d", j), 32'(irq), (j >= 19) ? 32'h1 : 32'h0);
      rd(ADDR_DATA, (j >= 18) ? 32'h1 : 32'h0, $sformatf("deb_lat_%0d", j));
    end
    rd(ADDR_EDGE, 32'h0000_0001, "edge_set");
    chk("irq_set", 32'(irq), 32'h1);
    wr(ADDR_EDGE, 32'h0000_0001);
    chk("irq_w1c", 32'(irq), 32'h0);
    rd(ADDR_EDGE, 32'h0, "edge_w1c");

    // Masked: event captured, irq stays low
    wr(ADDR_MASK, 32'h0);
    pio_in = 8'h00;
    idle(20);
    rd(ADDR_DATA, 32'h0, "data_fall");
    rd(ADDR_EDGE, 32'h0, "no_fall_event");
    pio_in = 8'h01;
    idle(20);
    rd(ADDR_EDGE, 32'h0000_0001, "edge_masked");
    chk("irq_masked", 32'(irq), 32'h0);
    wr(ADDR_EDGE, 32'h0000_0001);

    // W1C of bit 2 in the same cycle its rising event is captured
    pio_in = 8'h05;
    idle(18);
    wr(ADDR_EDGE, 32'h0000_0004);
    rd(ADDR_EDGE, 32'h0000_0004, "w1c_collision");
    wr(ADDR_EDGE, 32'h0000_0004);
    rd(ADDR_EDGE, 32'h0, "w1c_after");

    // Reset 8 cycles into a debounce discards all progress
    pio_in = 8'h07;
    idle(8);
    rst_n = 1'b0;
    #1;
    chk("midrst_out", 32'(pio_out), 32'h0000_00A5);
    chk("midrst_irq", 32'(irq), 32'h0);
    chk("midrst_rdata", avs_readdata, 32'h0);
    idle(2);
    rst_n = 1'b1;
    for (int j = 0; j < 20; j++) begin
      rd(ADDR_DATA, (j >= 18) ? 32'h7 : 32'h0, $sformatf("post_rst_%0d", j));
    end
    rd(ADDR_EDGE, 32'h0000_0007, "post_rst_edge");
    chk("post_rst_irq", 32'(irq), 32'h0);
    rd(ADDR_OUT, 32'h0000_00A5, "post_rst_out");

    idle(2);
    chk("sb_drained", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
